// File: rtl/execute_ldst_sequencer.sv
// execute_ldst_sequencer
// Carries one load/store at a time from the execute-stage LDST adder to the
// L1 data interface, then hands the aligned result (plus any deferred SPR
// update) to writeback. Misaligned requests and unanswered requests come back
// as faults instead of data.
//
// Handshakes (all three are hold-until-taken):
//   prev : a request transfers on a cycle with iPREV_VALID & !oPREV_BUSY & !iFLUSH.
//   ldst : oLDST_REQ and the oLDST_* fields stay stable until a cycle with
//          oLDST_REQ & !iLDST_BUSY; exactly one response (iLDST_VALID) follows,
//          no earlier than the cycle after that transfer.
//   next : oNEXT_VALID and the oNEXT_* fields stay stable until a cycle with
//          oNEXT_VALID & !iNEXT_BUSY (or a flush drops them).
module execute_ldst_sequencer #(
  parameter int P_TIMEOUT = 256,
  parameter int P_TO_W    = 16
) (
  input  logic        iCLOCK,
  input  logic        iRESET_SYNC,
  input  logic        iFLUSH,
  input  logic        iPREV_VALID,
  output logic        oPREV_BUSY,
  input  logic        iPREV_RW,
  input  logic [31:0] iPREV_ADDR,
  input  logic [31:0] iPREV_DATA,
  input  logic [1:0]  iPREV_ORDER,
  input  logic [3:0]  iPREV_MASK,
  input  logic [1:0]  iPREV_SHIFT,
  input  logic        iPREV_SPR_VALID,
  input  logic [31:0] iPREV_SPR,
  output logic        oLDST_REQ,
  input  logic        iLDST_BUSY,
  output logic        oLDST_RW,
  output logic [31:0] oLDST_ADDR,
  output logic [31:0] oLDST_DATA,
  output logic [1:0]  oLDST_ORDER,
  output logic [3:0]  oLDST_MASK,
  input  logic        iLDST_VALID,
  input  logic [31:0] iLDST_DATA,
  output logic        oNEXT_VALID,
  input  logic        iNEXT_BUSY,
  output logic [31:0] oNEXT_DATA,
  output logic        oNEXT_SPR_VALID,
  output logic [31:0] oNEXT_SPR,
  output logic [1:0]  oNEXT_FAULT,
  output logic [1:0]  oDEBUG_STATE
);

  localparam logic [1:0] L_IDLE = 2'd0;
  localparam logic [1:0] L_REQ  = 2'd1;
  localparam logic [1:0] L_WAIT = 2'd2;
  localparam logic [1:0] L_DONE = 2'd3;

  localparam logic [1:0] L_FAULT_NONE     = 2'd0;
  localparam logic [1:0] L_FAULT_MISALIGN = 2'd1;
  localparam logic [1:0] L_FAULT_TIMEOUT  = 2'd2;

  // Last WAIT cycle before giving up on the memory response.
  localparam logic [P_TO_W-1:0] L_TO_LAST = P_TO_W'(P_TIMEOUT - 1);

  logic [1:0]        state;
  logic [P_TO_W-1:0] to_cnt;
  logic              discard;

  logic              req_rw;
  logic [31:0]       req_addr;
  logic [31:0]       req_data;
  logic [1:0]        req_order;
  logic [3:0]        req_mask;
  logic [1:0]        req_shift;

  logic              wb_spr_valid;
  logic [31:0]       wb_spr;
  logic [31:0]       wb_data;
  logic [1:0]        wb_fault;

  logic [7:0]        load_byte;
  logic [31:0]       load_aligned;
  logic              wait_end;

  // Select the addressed lane of the raw load word and zero-extend it.
  always_comb begin
    load_byte    = iLDST_DATA[7:0];
    load_aligned = iLDST_DATA;
    case (req_shift)
      2'd1:    load_byte = iLDST_DATA[15:8];
      2'd2:    load_byte = iLDST_DATA[23:16];
      2'd3:    load_byte = iLDST_DATA[31:24];
      default: load_byte = iLDST_DATA[7:0];
    endcase
    if (req_rw) begin
      load_aligned = 32'h0;
    end else begin
      case (req_order)
        2'd0:    load_aligned = {24'h0, load_byte};
        2'd1:    load_aligned = {16'h0, req_shift[1] ? iLDST_DATA[31:16] : iLDST_DATA[15:0]};
        default: load_aligned = iLDST_DATA;
      endcase
    end
  end

  // WAIT ends on a response or on the final timeout cycle.
  always_comb begin
    wait_end = iLDST_VALID || (to_cnt == L_TO_LAST);
  end

  // Main sequencer: accept, issue, wait for response, hold writeback.
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      state        <= L_IDLE;
      to_cnt       <= '0;
      discard      <= 1'b0;
      req_rw       <= 1'b0;
      req_addr     <= 32'h0;
      req_data     <= 32'h0;
      req_order    <= 2'd0;
      req_mask     <= 4'h0;
      req_shift    <= 2'd0;
      wb_spr_valid <= 1'b0;
      wb_spr       <= 32'h0;
      wb_data      <= 32'h0;
      wb_fault     <= L_FAULT_NONE;
    end else begin
      case (state)
        L_IDLE: begin
          if (iPREV_VALID && !iFLUSH) begin
            req_rw    <= iPREV_RW;
            req_addr  <= iPREV_ADDR;
            req_data  <= iPREV_DATA;
            req_order <= iPREV_ORDER;
            req_mask  <= iPREV_MASK;
            req_shift <= iPREV_SHIFT;
            wb_spr    <= iPREV_SPR;
            if (iPREV_MASK != 4'h0) begin
              state        <= L_REQ;
              wb_spr_valid <= iPREV_SPR_VALID;
              wb_fault     <= L_FAULT_NONE;
            end else begin
              // Misaligned: report straight away, never touch memory.
              state        <= L_DONE;
              wb_spr_valid <= 1'b0;
              wb_data      <= 32'h0;
              wb_fault     <= L_FAULT_MISALIGN;
            end
          end
        end
        L_REQ: begin
          if (!iLDST_BUSY) begin
            // Request is gone to memory; a flush now can only discard the result.
            state   <= L_WAIT;
            to_cnt  <= '0;
            discard <= iFLUSH;
          end else if (iFLUSH) begin
            state <= L_IDLE;
          end
        end
        L_WAIT: begin
          if (wait_end) begin
            to_cnt  <= '0;
            discard <= 1'b0;
            if (discard || iFLUSH) begin
              state <= L_IDLE;
            end else if (iLDST_VALID) begin
              state    <= L_DONE;
              wb_data  <= load_aligned;
              wb_fault <= L_FAULT_NONE;
            end else begin
              state        <= L_DONE;
              wb_data      <= 32'h0;
              wb_fault     <= L_FAULT_TIMEOUT;
              wb_spr_valid <= 1'b0;
            end
          end else begin
            to_cnt <= to_cnt + 1'b1;
            if (iFLUSH) begin
              discard <= 1'b1;
            end
          end
        end
        default: begin
          if (iFLUSH || !iNEXT_BUSY) begin
            state <= L_IDLE;
          end
        end
      endcase
    end
  end

  assign oPREV_BUSY      = (state != L_IDLE);
  assign oLDST_REQ       = (state == L_REQ);
  assign oLDST_RW        = req_rw;
  assign oLDST_ADDR      = req_addr;
  assign oLDST_DATA      = req_data;
  assign oLDST_ORDER     = req_order;
  assign oLDST_MASK      = req_mask;
  assign oNEXT_VALID     = (state == L_DONE);
  assign oNEXT_DATA      = wb_data;
  assign oNEXT_SPR_VALID = (state == L_DONE) && wb_spr_valid;
  assign oNEXT_SPR       = wb_spr;
  assign oNEXT_FAULT     = wb_fault;
  assign oDEBUG_STATE    = state;

endmodule

// File: tb/tb_execute_ldst_sequencer.sv
// tb_execute_ldst_sequencer
// Directed cases for the documented scenarios followed by randomized
// transactions, checked against a transaction-level model of the sequencer.
module tb_execute_ldst_sequencer;

  localparam int TO = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        iFLUSH, iPREV_VALID, oPREV_BUSY, iPREV_RW;
  logic [31:0] iPREV_ADDR, iPREV_DATA, iPREV_SPR;
  logic [1:0]  iPREV_ORDER, iPREV_SHIFT;
  logic [3:0]  iPREV_MASK;
  logic        iPREV_SPR_VALID;
  logic        oLDST_REQ, iLDST_BUSY, oLDST_RW, iLDST_VALID;
  logic [31:0] oLDST_ADDR, oLDST_DATA, iLDST_DATA;
  logic [1:0]  oLDST_ORDER;
  logic [3:0]  oLDST_MASK;
  logic        oNEXT_VALID, iNEXT_BUSY, oNEXT_SPR_VALID;
  logic [31:0] oNEXT_DATA, oNEXT_SPR;
  logic [1:0]  oNEXT_FAULT, dbg_state;

  execute_ldst_sequencer #(.P_TIMEOUT(TO), .P_TO_W(3)) dut (
    .iCLOCK(clk), .iRESET_SYNC(rst), .iFLUSH(iFLUSH),
    .iPREV_VALID(iPREV_VALID), .oPREV_BUSY(oPREV_BUSY), .iPREV_RW(iPREV_RW),
    .iPREV_ADDR(iPREV_ADDR), .iPREV_DATA(iPREV_DATA), .iPREV_ORDER(iPREV_ORDER),
    .iPREV_MASK(iPREV_MASK), .iPREV_SHIFT(iPREV_SHIFT),
    .iPREV_SPR_VALID(iPREV_SPR_VALID), .iPREV_SPR(iPREV_SPR),
    .oLDST_REQ(oLDST_REQ), .iLDST_BUSY(iLDST_BUSY), .oLDST_RW(oLDST_RW),
    .oLDST_ADDR(oLDST_ADDR), .oLDST_DATA(oLDST_DATA), .oLDST_ORDER(oLDST_ORDER),
    .oLDST_MASK(oLDST_MASK), .iLDST_VALID(iLDST_VALID), .iLDST_DATA(iLDST_DATA),
    .oNEXT_VALID(oNEXT_VALID), .iNEXT_BUSY(iNEXT_BUSY), .oNEXT_DATA(oNEXT_DATA),
    .oNEXT_SPR_VALID(oNEXT_SPR_VALID), .oNEXT_SPR(oNEXT_SPR),
    .oNEXT_FAULT(oNEXT_FAULT), .oDEBUG_STATE(dbg_state)
  );

  int checks = 0;
  int failures = 0;
  int hs_count = 0;
  int hs_exp = 0;
  // {fault[1:0], spr_valid, spr[31:0], data[31:0]}
  logic [66:0] exp_q[$];
  logic [66:0] wb_e;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [3:0] calc_mask(input logic [1:0] a, input logic [1:0] order);
    case (order)
      2'd0:    return 4'b0001 << a;
      2'd1:    return a[0] ? 4'h0 : (a[1] ? 4'b1100 : 4'b0011);
      default: return (a == 2'd0) ? 4'hF : 4'h0;
    endcase
  endfunction

  function automatic logic [31:0] align(input logic [31:0] d, input logic [1:0] order,
                                        input logic [1:0] sh);
    case (order)
      2'd0:    return (d >> (8 * sh)) & 32'h0000_00FF;
      2'd1:    return (d >> (8 * sh)) & 32'h0000_FFFF;
      default: return d;
    endcase
  endfunction

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (oLDST_REQ && !iLDST_BUSY) hs_count++;
      if (oNEXT_SPR_VALID && !oNEXT_VALID) check("spr_without_valid", 32'd1, 32'd0);
      if (oNEXT_VALID && !iNEXT_BUSY) begin
        if (exp_q.size() == 0) begin
          check("wb_unexpected", 32'd1, 32'd0);
        end else begin
          wb_e = exp_q.pop_front();
          check("wb_fault", {30'h0, oNEXT_FAULT}, {30'h0, wb_e[66:65]});
          check("wb_spr_valid", {31'h0, oNEXT_SPR_VALID}, {31'h0, wb_e[64]});
          if (wb_e[64]) check("wb_spr", oNEXT_SPR, wb_e[63:32]);
          if (wb_e[66:65] == 2'd0) check("wb_data", oNEXT_DATA, wb_e[31:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic rw, input logic [31:0] addr, input logic [1:0] order,
                        input logic [31:0] wdata, input logic spr_v, input logic [31:0] spr,
                        input logic [31:0] rdata, input int busy_n, input int resp_k,
                        input int nbusy_n, input int flush_req, input int flush_wait,
                        input bit flush_done, input bit late_resp);
    logic [3:0]  mask;
    logic [1:0]  sh;
    logic [1:0]  fault;
    logic [31:0] data;
    logic        exp_sprv;
    bit          timed_out;
    bit          discarded;
    int          end_k;
    mask      = calc_mask(addr[1:0], order);
    sh        = addr[1:0];
    timed_out = (resp_k >= TO);
    end_k     = timed_out ? TO - 1 : resp_k;
    discarded = 1'b0;
    for (int i = 0; i < 20 && oPREV_BUSY; i++) tick();
    check("idle_before_accept", {31'h0, oPREV_BUSY}, 32'd0);
    iPREV_RW = rw; iPREV_ADDR = addr; iPREV_DATA = wdata; iPREV_ORDER = order;
    iPREV_MASK = mask; iPREV_SHIFT = sh; iPREV_SPR_VALID = spr_v; iPREV_SPR = spr;
    iPREV_VALID = 1'b1;
    tick();
    iPREV_VALID = 1'b0; iPREV_ADDR = $urandom; iPREV_DATA = $urandom; iPREV_SPR = $urandom;
    check("busy_after_accept", {31'h0, oPREV_BUSY}, 32'd1);
    if (mask != 4'h0) begin
      for (int i = 0; i <= busy_n; i++) begin
        iLDST_BUSY = (i < busy_n);
        iFLUSH = (i == flush_req);
        check("req", {31'h0, oLDST_REQ}, 32'd1);
        check("req_addr", oLDST_ADDR, addr);
        check("req_data", oLDST_DATA, wdata);
        check("req_rw", {31'h0, oLDST_RW}, {31'h0, rw});
        check("req_order", {30'h0, oLDST_ORDER}, {30'h0, order});
        check("req_mask", {28'h0, oLDST_MASK}, {28'h0, mask});
        tick();
        iFLUSH = 1'b0;
        if (i == flush_req && i < busy_n) begin
          iLDST_BUSY = 1'b0;
          check("abort_no_req", {31'h0, oLDST_REQ}, 32'd0);
          check("abort_idle", {31'h0, oPREV_BUSY}, 32'd0);
          return;
        end
      end
      iLDST_BUSY = 1'b0;
      hs_exp++;
      discarded = (flush_req == busy_n);
      for (int j = 0; j <= end_k; j++) begin
        iFLUSH = (j == flush_wait);
        iLDST_VALID = (!timed_out && j == resp_k);
        iLDST_DATA = iLDST_VALID ? rdata : $urandom;
        if (j == flush_wait) discarded = 1'b1;
        check("wait_no_req", {31'h0, oLDST_REQ}, 32'd0);
        check("wait_no_wb", {31'h0, oNEXT_VALID}, 32'd0);
        tick();
        iFLUSH = 1'b0; iLDST_VALID = 1'b0;
      end
      fault = timed_out ? 2'd2 : 2'd0;
      data  = (rw || timed_out) ? 32'h0 : align(rdata, order, sh);
    end else begin
      fault = 2'd1;
      data  = 32'h0;
    end
    exp_sprv = spr_v && (fault == 2'd0);
    if (discarded) begin
      check("discard_no_wb", {31'h0, oNEXT_VALID}, 32'd0);
      check("discard_idle", {31'h0, oPREV_BUSY}, 32'd0);
    end else if (flush_done) begin
      iNEXT_BUSY = 1'b1;
      check("done_valid", {31'h0, oNEXT_VALID}, 32'd1);
      iFLUSH = 1'b1;
      tick();
      iFLUSH = 1'b0; iNEXT_BUSY = 1'b0;
      check("flush_done_drop", {31'h0, oNEXT_VALID}, 32'd0);
      check("flush_done_idle", {31'h0, oPREV_BUSY}, 32'd0);
    end else begin
      exp_q.push_back({fault, exp_sprv, spr, data});
      for (int i = 0; i <= nbusy_n; i++) begin
        iNEXT_BUSY = (i < nbusy_n);
        check("done_valid", {31'h0, oNEXT_VALID}, 32'd1);
        check("done_no_req", {31'h0, oLDST_REQ}, 32'd0);
        check("spr_hold", {31'h0, oNEXT_SPR_VALID}, {31'h0, exp_sprv});
        if (exp_sprv) check("spr_value_hold", oNEXT_SPR, spr);
        tick();
      end
      iNEXT_BUSY = 1'b0;
      check("wb_released", {31'h0, oNEXT_VALID}, 32'd0);
      check("idle_after_wb", {31'h0, oPREV_BUSY}, 32'd0);
    end
    if (late_resp) begin
      iLDST_VALID = 1'b1; iLDST_DATA = $urandom;
      tick();
      iLDST_VALID = 1'b0;
      check("late_resp_idle", {31'h0, oPREV_BUSY}, 32'd0);
      check("late_resp_no_wb", {31'h0, oNEXT_VALID}, 32'd0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; iFLUSH = 1'b0; iPREV_VALID = 1'b0; iPREV_RW = 1'b0;
    iPREV_ADDR = 32'h0; iPREV_DATA = 32'h0; iPREV_ORDER = 2'd0; iPREV_MASK = 4'h0;
    iPREV_SHIFT = 2'd0; iPREV_SPR_VALID = 1'b0; iPREV_SPR = 32'h0;
    iLDST_BUSY = 1'b0; iLDST_VALID = 1'b0; iLDST_DATA = 32'h0; iNEXT_BUSY = 1'b0;
    repeat (3) tick();
    check("rst_prev_busy", {31'h0, oPREV_BUSY}, 32'd0);
    check("rst_ldst_req", {31'h0, oLDST_REQ}, 32'd0);
    check("rst_ldst_addr", oLDST_ADDR, 32'h0);
    check("rst_next_valid", {31'h0, oNEXT_VALID}, 32'd0);
    check("rst_next_data", oNEXT_DATA, 32'h0);
    check("rst_next_fault", {30'h0, oNEXT_FAULT}, 32'd0);
    check("rst_next_spr_valid", {31'h0, oNEXT_SPR_VALID}, 32'd0);
    rst = 1'b0;
    tick();

    // LD8 at 0x103, zero wait
    run_op(1'b0, 32'h103, 2'd0, 32'h0, 1'b0, 32'h0, 32'hAABBCCDD, 0, 0, 0, -1, -1, 1'b0, 1'b0);
    // LD16 shift 2 with memory busy for 3 cycles
    run_op(1'b0, 32'h102, 2'd1, 32'h0, 1'b0, 32'h0, 32'hAABBCCDD, 3, 1, 0, -1, -1, 1'b0, 1'b0);
    // PUSH store with SPR update, next stage busy for 2 cycles
    run_op(1'b1, 32'h0FFC, 2'd2, 32'h1234_5678, 1'b1, 32'h0FFC, 32'h0, 0, 0, 2, -1, -1, 1'b0, 1'b0);
    // Misaligned LD16 at 0x101
    run_op(1'b0, 32'h101, 2'd1, 32'h0, 1'b1, 32'h55, 32'h0, 0, 0, 1, -1, -1, 1'b0, 1'b0);
    // No response: timeout, then a late response in IDLE
    run_op(1'b0, 32'h200, 2'd2, 32'h0, 1'b1, 32'h77, 32'h0, 0, 99, 0, -1, -1, 1'b0, 1'b1);
    // Flush in WAIT, response after; then a normal load
    run_op(1'b0, 32'h300, 2'd2, 32'h0, 1'b0, 32'h0, 32'hDEADBEEF, 0, 2, 0, -1, 1, 1'b0, 1'b0);
    run_op(1'b0, 32'h304, 2'd2, 32'h0, 1'b0, 32'h0, 32'hCAFEF00D, 1, 1, 0, -1, -1, 1'b0, 1'b0);
    // Flush in REQ without handshake, flush with handshake, flush in DONE
    run_op(1'b1, 32'h400, 2'd2, 32'h9, 1'b0, 32'h0, 32'h0, 2, 0, 0, 0, -1, 1'b0, 1'b0);
    run_op(1'b0, 32'h401, 2'd0, 32'h0, 1'b0, 32'h0, 32'h11223344, 1, 1, 0, 1, -1, 1'b0, 1'b0);
    run_op(1'b0, 32'h402, 2'd1, 32'h0, 1'b1, 32'h88, 32'h11223344, 0, 0, 1, -1, -1, 1'b1, 1'b0);

    // Flush in IDLE blocks acceptance
    iPREV_VALID = 1'b1; iPREV_MASK = 4'hF; iPREV_ORDER = 2'd2; iFLUSH = 1'b1;
    tick();
    iPREV_VALID = 1'b0; iFLUSH = 1'b0;
    check("flush_idle_not_accepted", {31'h0, oPREV_BUSY}, 32'd0);
    tick();
    check("flush_idle_no_req", {31'h0, oLDST_REQ}, 32'd0);

    // Reset while waiting for a response
    iPREV_RW = 1'b0; iPREV_ADDR = 32'h500; iPREV_ORDER = 2'd2; iPREV_MASK = 4'hF;
    iPREV_SHIFT = 2'd0; iPREV_SPR_VALID = 1'b1; iPREV_VALID = 1'b1;
    tick();
    iPREV_VALID = 1'b0;
    tick();
    hs_exp++;
    check("midrst_in_wait", {31'h0, oPREV_BUSY}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_idle", {31'h0, oPREV_BUSY}, 32'd0);
    check("midrst_addr_cleared", oLDST_ADDR, 32'h0);
    iLDST_VALID = 1'b1; iLDST_DATA = 32'h12345678;
    tick();
    iLDST_VALID = 1'b0;
    check("midrst_resp_ignored", {31'h0, oNEXT_VALID}, 32'd0);
    check("midrst_still_idle", {31'h0, oPREV_BUSY}, 32'd0);

    // Randomized transactions
    for (int n = 0; n < 80; n++) begin
      logic        r_rw;
      logic [31:0] r_addr;
      logic [1:0]  r_order;
      int          r_busy, r_resp, r_nbusy, r_fr, r_fw, sel, r_end;
      bit          r_fd;
      r_rw    = 1'($urandom_range(0, 1));
      r_addr  = $urandom;
      r_order = 2'($urandom_range(0, 2));
      r_busy  = $urandom_range(0, 3);
      r_resp  = $urandom_range(0, 5);
      r_nbusy = $urandom_range(0, 2);
      r_end   = (r_resp >= TO) ? TO - 1 : r_resp;
      r_fr = -1; r_fw = -1; r_fd = 1'b0;
      sel = $urandom_range(0, 9);
      if (sel == 0) r_fr = $urandom_range(0, r_busy);
      else if (sel == 1) r_fw = $urandom_range(0, r_end);
      else if (sel == 2) r_fd = 1'b1;
      run_op(r_rw, r_addr, r_order, $urandom, 1'($urandom_range(0, 1)), $urandom, $urandom,
             r_busy, r_resp, r_nbusy, r_fr, r_fw, r_fd, (r_resp >= TO));
    end

    repeat (3) tick();
    check("handshake_count", hs_count, hs_exp);
    check("exp_q_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
